// File: rtl/m_wbregbank.sv
// m_wbregbank
// Wishbone classic slave register bank. It holds NREGS 32-bit registers with
// byte-lane writes and a configurable number of wait states before ACK_O.
//   reg0        sticky hardware event flags. hw_set pulses set them. A write
//               clears each bit written as 1 (write-1-to-clear).
//   reg1        interrupt enable mask. irq_o = registered |(reg0 & reg1).
//   reg2..N-1   plain read/write registers that reset to RSTVAL.
// STB_I is already address-decoded upstream. ADR_I is the word index.

module m_wbregbank #(
    parameter int          NREGS      = 4,
    parameter int          WAITSTATES = 0,
    parameter logic [31:0] RSTVAL     = 32'h0000_0000,
    localparam int         ADRW       = $clog2(NREGS)
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic            STB_I,
    input  logic            WE_I,
    input  logic [ADRW-1:0] ADR_I,
    input  logic [3:0]      SEL_I,
    input  logic [31:0]     DAT_I,
    input  logic [31:0]     hw_set,
    output logic            ACK_O,
    output logic [31:0]     DAT_O,
    output logic            irq_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t          state;
    logic [3:0]      cnt;

    // Request captured in IDLE. Later wait states use these values, so the
    // master may change the bus while it holds STB_I.
    logic            lat_we;
    logic [ADRW-1:0] lat_adr;
    logic [3:0]      lat_sel;
    logic [31:0]     lat_dat;

    logic [31:0]     regs [NREGS];

    // The request currently in effect. In IDLE with no wait states, the
    // transfer completes on the same edge that samples the bus. The live bus
    // values are therefore used directly in that case.
    logic            in_idle;
    logic            cur_we;
    logic [ADRW-1:0] cur_adr;
    logic [3:0]      cur_sel;
    logic [31:0]     cur_dat;

    logic            go_ack;
    logic            wr_commit;
    logic [31:0]     wmask;
    logic [31:0]     wr_data;
    logic [31:0]     w1c;
    logic [31:0]     reg0_next;
    logic [31:0]     reg1_next;

    // Select between the live bus and the latched request.
    always_comb begin
        in_idle = (state == S_IDLE);
        cur_we  = in_idle ? WE_I  : lat_we;
        cur_adr = in_idle ? ADR_I : lat_adr;
        cur_sel = in_idle ? SEL_I : lat_sel;
        cur_dat = in_idle ? DAT_I : lat_dat;
    end

    // Decide whether this edge enters ACK. A dropped strobe in WAIT aborts.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        go_ack = 1'b0;
        case (state)
            S_IDLE:  go_ack = STB_I && (WAITSTATES == 0);
            S_WAIT:  go_ack = STB_I && (cnt == 4'd0);
            default: go_ack = 1'b0;
        endcase
    end

    // Build the byte-lane write data and the next values of reg0 and reg1.
    // Computing them here lets irq_o be registered from the next state.
    always_comb begin
        wmask     = {{8{cur_sel[3]}}, {8{cur_sel[2]}}, {8{cur_sel[1]}}, {8{cur_sel[0]}}};
        wr_commit = go_ack && cur_we;
        wr_data   = (regs[cur_adr] & ~wmask) | (cur_dat & wmask);
        w1c       = (wr_commit && (cur_adr == '0)) ? (cur_dat & wmask) : 32'h0;
        // hw_set is ORed in after the clear, so a new event wins over a
        // clear of the same bit. A write to reg0 can only clear bits.
        reg0_next = (regs[0] & ~w1c) | hw_set;
        reg1_next = (wr_commit && (cur_adr == ADRW'(1))) ? wr_data : regs[1];
    end

    // Transfer FSM with registered ACK_O and DAT_O.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            lat_we  <= 1'b0;
            lat_adr <= '0;
            lat_sel <= 4'h0;
            lat_dat <= 32'h0;
            ACK_O   <= 1'b0;
            DAT_O   <= 32'h0;
        end else begin
            // NOTE: state is updated only with non-blocking assignments, so every flop samples pre-edge values whatever the statement order.
            ACK_O <= go_ack;
            DAT_O <= (go_ack && !cur_we) ? regs[cur_adr] : 32'h0;
            case (state)
                S_IDLE: begin
                    if (STB_I) begin
                        lat_we  <= WE_I;
                        lat_adr <= ADR_I;
                        lat_sel <= SEL_I;
                        lat_dat <= DAT_I;
                        if (WAITSTATES == 0) begin
                            state <= S_ACK;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'(WAITSTATES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (!STB_I) begin
                        state <= S_IDLE;
                    end else if (cnt == 4'd0) begin
                        state <= S_ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Update the register bank and the interrupt output.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            // NOTE: this array is a small set of flops, not a RAM macro, so every entry can be reset to a known value.
            regs[0] <= 32'h0;
            regs[1] <= 32'h0;
            for (int i = 2; i < NREGS; i++) begin
                regs[i] <= RSTVAL;
            end
            irq_o <= 1'b0;
        end else begin
            regs[0] <= reg0_next;
            regs[1] <= reg1_next;
            for (int i = 2; i < NREGS; i++) begin
                if (wr_commit && (cur_adr == ADRW'(i))) begin
                    regs[i] <= wr_data;
                end
            end
            irq_o <= |(reg0_next & reg1_next);
        end
    end

endmodule

// File: tb/tb_m_wbregbank.sv
// Testbench for m_wbregbank. It uses three instances that share the bus
// signals but have separate strobes:
//   unit 0: NREGS=4,  WAITSTATES=0
//   unit 1: NREGS=4,  WAITSTATES=3
//   unit 2: NREGS=16, WAITSTATES=0

module tb_m_wbregbank;

    localparam logic [31:0] RV = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  stb;
    logic        we;
    logic [3:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] hw_set;
    logic [2:0]  ack;
    logic [2:0]  irq;
    logic [31:0] rdat0, rdat1, rdat2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    m_wbregbank #(.NREGS(4), .WAITSTATES(0), .RSTVAL(RV)) u_ws0 (
        .CLK_I(clk), .RST_I(rst), .STB_I(stb[0]), .WE_I(we), .ADR_I(adr[1:0]),
        .SEL_I(sel), .DAT_I(dat), .hw_set(hw_set),
        .ACK_O(ack[0]), .DAT_O(rdat0), .irq_o(irq[0])
    );

    m_wbregbank #(.NREGS(4), .WAITSTATES(3), .RSTVAL(RV)) u_ws3 (
        .CLK_I(clk), .RST_I(rst), .STB_I(stb[1]), .WE_I(we), .ADR_I(adr[1:0]),
        .SEL_I(sel), .DAT_I(dat), .hw_set(hw_set),
        .ACK_O(ack[1]), .DAT_O(rdat1), .irq_o(irq[1])
    );

    m_wbregbank #(.NREGS(16), .WAITSTATES(0), .RSTVAL(RV)) u_n16 (
        .CLK_I(clk), .RST_I(rst), .STB_I(stb[2]), .WE_I(we), .ADR_I(adr),
        .SEL_I(sel), .DAT_I(dat), .hw_set(hw_set),
        .ACK_O(ack[2]), .DAT_O(rdat2), .irq_o(irq[2])
    );

    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp_rd;
    } vec_t;

    function automatic logic [31:0] rdat_of(input int u);
        case (u)
            0:       return rdat0;
            1:       return rdat1;
            default: return rdat2;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer on unit u. It reports the read data captured
    // with ACK_O and the number of edges from the strobe to ACK_O. It then
    // checks that ACK_O was a single-cycle pulse and that DAT_O returned to 0.
    task automatic do_xfer(input int u, input logic w, input logic [3:0] a,
                           input logic [3:0] s, input logic [31:0] d,
                           output logic [31:0] rd, output int lat);
        we = w; adr = a; sel = s; dat = d;
        stb[u] = 1'b1;
        lat = 0;
        rd = 32'h0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ack[u]) begin
                lat = i;
                rd  = rdat_of(u);
                break;
            end
        end
        stb[u] = 1'b0;
        if (lat == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL xfer_timeout: unit %0d got no ACK_O within 40 cycles, expected one", u);
        end
        tick();
        check($sformatf("ack_pulse_u%0d", u), 32'(ack[u]), 32'h0);
        check($sformatf("dat_idle_u%0d", u), rdat_of(u), 32'h0);
    endtask

    task automatic rd_chk(input string name, input int u, input logic [3:0] a,
                          input logic [31:0] exp, input int exp_lat);
        logic [31:0] rd;
        int          lat;
        do_xfer(u, 1'b0, a, 4'h0, 32'h0, rd, lat);
        check({name, "_data"}, rd, exp);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic wr(input int u, input logic [3:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] rd;
        int          lat;
        do_xfer(u, 1'b1, a, s, d, rd, lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [12];
        logic [31:0] rd;
        int          lat;
        int          acks;
        logic        exp_ack;

        // Register-file vectors for unit 0: {we, adr, sel, dat, expected read data}.
        tbl[0]  = '{1'b1, 4'd2, 4'hF,    32'hDEAD_BEEF, 32'h0};
        tbl[1]  = '{1'b1, 4'd2, 4'b0010, 32'h0000_AA00, 32'h0};
        tbl[2]  = '{1'b0, 4'd2, 4'h0,    32'h0,         32'hDEAD_AAEF};
        tbl[3]  = '{1'b1, 4'd3, 4'b1001, 32'h1122_3344, 32'h0};
        tbl[4]  = '{1'b0, 4'd3, 4'h0,    32'h0,         32'h1134_5644};
        tbl[5]  = '{1'b1, 4'd1, 4'hF,    32'h0,         32'h0};
        tbl[6]  = '{1'b0, 4'd1, 4'h0,    32'h0,         32'h0};
        tbl[7]  = '{1'b1, 4'd3, 4'h0,    32'hFFFF_FFFF, 32'h0};
        tbl[8]  = '{1'b0, 4'd3, 4'h0,    32'h0,         32'h1134_5644};
        tbl[9]  = '{1'b1, 4'd2, 4'b0100, 32'h0077_0000, 32'h0};
        tbl[10] = '{1'b0, 4'd2, 4'h0,    32'h0,         32'hDE77_AAEF};
        tbl[11] = '{1'b0, 4'd0, 4'h0,    32'h0,         32'h0};

        rst = 1'b1; stb = 3'b000; we = 1'b0; adr = 4'h0; sel = 4'h0;
        dat = 32'h0; hw_set = 32'h0;

        // Outputs while reset is held.
        repeat (2) tick();
        check("rst_ack", 32'(ack[0]), 32'h0);
        check("rst_dat", rdat0, 32'h0);
        check("rst_irq", 32'(irq[0]), 32'h0);
        check("rst_ack_ws3", 32'(ack[1]), 32'h0);
        rst = 1'b0;
        tick();

        // Reset during writes: unit 1 is mid wait-state, unit 0 is on its commit cycle.
        we = 1'b1; adr = 4'd2; sel = 4'hF; dat = 32'hAAAA_5555;
        stb[1] = 1'b1;
        repeat (2) tick();
        stb[0] = 1'b1;
        rst = 1'b1;
        tick();
        check("midrst_ack", 32'(ack[0]), 32'h0);
        check("midrst_dat", rdat0, 32'h0);
        rst = 1'b0;
        stb = 3'b000;
        acks = 0;
        repeat (6) begin
            tick();
            if (ack[0] || ack[1]) acks++;
        end
        check("midrst_noack", 32'(acks), 32'h0);
        rd_chk("midrst_reg2_u0", 0, 4'd2, RV, 1);
        rd_chk("midrst_reg2_u1", 1, 4'd2, RV, 4);

        // Table-driven register-file vectors on unit 0.
        for (int i = 0; i < 12; i++) begin
            do_xfer(0, tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, rd, lat);
            check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_lat", i), 32'(lat), 32'd1);
        end

        // Held strobe with three wait states: one ACK every five cycles.
        we = 1'b0; adr = 4'd2; sel = 4'h0;
        stb[1] = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            exp_ack = (c == 4) || (c == 9) || (c == 14);
            check($sformatf("ws_ack_c%0d", c), 32'(ack[1]), 32'(exp_ack));
            check($sformatf("ws_dat_c%0d", c), rdat1, exp_ack ? RV : 32'h0);
        end
        stb[1] = 1'b0;
        tick();

        // Master abort in a wait state: no ACK and no write.
        we = 1'b1; adr = 4'd2; sel = 4'hF; dat = 32'hFFFF_0000;
        stb[1] = 1'b1;
        repeat (2) tick();
        stb[1] = 1'b0;
        acks = 0;
        repeat (6) begin
            tick();
            if (ack[1]) acks++;
        end
        check("abort_noack", 32'(acks), 32'h0);
        rd_chk("abort_reg2", 1, 4'd2, RV, 4);

        // Sticky flags and write-1-to-clear.
        hw_set = 32'h5;
        tick();
        hw_set = 32'h0;
        rd_chk("sticky_set", 0, 4'd0, 32'h5, 1);
        wr(0, 4'd0, 4'hF, 32'h1);
        rd_chk("w1c_bit0", 0, 4'd0, 32'h4, 1);
        we = 1'b1; adr = 4'd0; sel = 4'hF; dat = 32'h1;
        hw_set = 32'h1;
        stb[0] = 1'b1;
        tick();
        hw_set = 32'h0;
        stb[0] = 1'b0;
        check("race_ack", 32'(ack[0]), 32'h1);
        tick();
        rd_chk("race_set_wins", 0, 4'd0, 32'h5, 1);
        wr(0, 4'd0, 4'hF, 32'h2);
        rd_chk("write_no_set", 0, 4'd0, 32'h5, 1);

        // Interrupt mask and irq_o timing.
        wr(0, 4'd0, 4'hF, 32'hFFFF_FFFF);
        rd_chk("clear_all", 0, 4'd0, 32'h0, 1);
        wr(0, 4'd1, 4'hF, 32'h4);
        check("irq_idle", 32'(irq[0]), 32'h0);
        hw_set = 32'h1;
        tick();
        hw_set = 32'h0;
        check("irq_masked", 32'(irq[0]), 32'h0);
        hw_set = 32'h4;
        tick();
        hw_set = 32'h0;
        check("irq_rise", 32'(irq[0]), 32'h1);
        tick();
        check("irq_hold", 32'(irq[0]), 32'h1);
        we = 1'b1; adr = 4'd0; sel = 4'b0001; dat = 32'h4;
        stb[0] = 1'b1;
        tick();
        stb[0] = 1'b0;
        check("irq_clr_ack", 32'(ack[0]), 32'h1);
        check("irq_fall", 32'(irq[0]), 32'h0);
        tick();
        rd_chk("irq_reg0_left", 0, 4'd0, 32'h1, 1);

        // Sixteen-register bank: fill indexes 2..15, then read them back.
        for (int k = 2; k < 16; k++) begin
            wr(2, 4'(k), 4'hF, 32'(k) * 32'h0101_0101);
        end
        for (int k = 2; k < 16; k++) begin
            rd_chk($sformatf("n16_reg%0d", k), 2, 4'(k), 32'(k) * 32'h0101_0101, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
